load_store_unit: RTL and testbench



---
 rtl/load_store_unit_pkg.sv | 36 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types, exception causes and op-classification helpers for the load/store unit.
package load_store_unit_pkg;

  typedef enum logic [3:0] {
    MEM_NOP,
    MEM_LB,
    MEM_LH,
    MEM_LW,
    MEM_LBU,
    MEM_LHU,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } lsu_state_t;

  localparam logic [31:0] EXC_LOAD_MISALIGNED  = 32'd4;
  localparam logic [31:0] EXC_LOAD_FAULT       = 32'd5;
  localparam logic [31:0] EXC_STORE_MISALIGNED = 32'd6;
  localparam logic [31:0] EXC_STORE_FAULT      = 32'd7;

  function automatic logic is_load(input mem_op_t op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment detect, byte enables, store steering, load extract/extend.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        misaligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    misaligned_o = 1'b0;
    be_o         = '0;
    wdata_o      = '0;
    rdata_o      = '0;
    case (op_i)
      MEM_LB, MEM_LBU, MEM_SB: be_o = 4'b0001 << addr_lo_i;
      MEM_LH, MEM_LHU, MEM_SH: begin
        misaligned_o = addr_lo_i[0];
        be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
      end
      MEM_LW, MEM_SW: begin
        misaligned_o = |addr_lo_i;
        be_o         = 4'b1111;
      end
      default: ;
    endcase
    case (op_i)
      MEM_SB:  wdata_o = {4{wdata_i[7:0]}};
      MEM_SH:  wdata_o = {2{wdata_i[15:0]}};
      MEM_SW:  wdata_o = wdata_i;
      MEM_LB:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      MEM_LH:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      MEM_LBU: rdata_o = {24'd0, shifted[7:0]};
      MEM_LHU: rdata_o = {16'd0, shifted[15:0]};
      MEM_LW:  rdata_o = rdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one data-bus transaction per accepted op, single outstanding.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              ready_o,
  input  mem_op_t           mem_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              exc_o,
  output logic [31:0]       exc_cause_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i
);

  lsu_state_t        state_q, state_d;
  mem_op_t           op_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       wait_q;
  logic              bus_req_q, bus_we_q, exc_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [31:0]       bus_wdata_q, rdata_q, cause_q;

  mem_op_t     al_op;
  logic [1:0]  al_lo;
  logic        al_mis;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        accept, timeout_hit;
  logic [31:0] fault_cause;

  // One aligner serves both phases: live inputs while IDLE (accept decode),
  // the registered op/offset afterwards (load extraction on the ack cycle).
  assign al_op = (state_q == IDLE) ? mem_op_i : op_q;
  assign al_lo = (state_q == IDLE) ? addr_i[1:0] : addr_lo_q;

  lsu_align u_align (
    .op_i        (al_op),
    .addr_lo_i   (al_lo),
    .wdata_i     (wdata_i),
    .rdata_i     (bus_rdata_i),
    .misaligned_o(al_mis),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata)
  );

  assign accept      = req_valid_i && (state_q == IDLE);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_q == TIMEOUT_CYCLES - 1);
  assign fault_cause = is_load(op_q) ? EXC_LOAD_FAULT : EXC_STORE_FAULT;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // BUS has a trailing cycle with the request already dropped before RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = ((mem_op_i == MEM_NOP) || al_mis) ? RESP : BUS;
      BUS:  if (!bus_req_q) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q        <= MEM_NOP;
      addr_lo_q   <= '0;
      wait_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      exc_q       <= 1'b0;
      cause_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q      <= mem_op_i;
          addr_lo_q <= addr_i[1:0];
          wait_q    <= '0;
          rdata_q   <= '0;
          exc_q     <= 1'b0;
          cause_q   <= '0;
          if (mem_op_i == MEM_NOP) begin
          end else if (al_mis) begin
            exc_q   <= 1'b1;
            cause_q <= is_load(mem_op_i) ? EXC_LOAD_MISALIGNED : EXC_STORE_MISALIGNED;
          end else begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= is_store(mem_op_i);
            bus_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
            bus_be_q    <= al_be;
            bus_wdata_q <= al_wdata;
          end
        end
        BUS: if (bus_req_q) begin
          if (bus_ack_i) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            if (bus_err_i) begin
              exc_q   <= 1'b1;
              cause_q <= fault_cause;
            end else begin
              rdata_q <= al_rdata;
            end
          end else if (timeout_hit) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            exc_q     <= 1'b1;
            cause_q   <= fault_cause;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign done_o      = (state_q == RESP);
  assign rdata_o     = rdata_q;
  assign exc_o       = exc_q;
  assign exc_cause_o = cause_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed + random bench for load_store_unit, checked against a behavioural model of the op rules.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk, rst_n;
  logic        req_valid, req_valid_to, bus_ack, bus_ack_to, bus_err;
  mem_op_t     mem_op;
  logic [31:0] addr, wdata, bus_rdata;

  logic        ready, done, exc, bus_req, bus_we;
  logic [31:0] rdata, cause, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        ready_to, done_to, exc_to, bus_req_to, bus_we_to;
  logic [31:0] rdata_to, cause_to, bus_addr_to, bus_wdata_to;
  logic [3:0]  bus_be_to;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  load_store_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .ready_o(ready),
    .mem_op_i(mem_op), .addr_i(addr), .wdata_i(wdata), .done_o(done),
    .rdata_o(rdata), .exc_o(exc), .exc_cause_o(cause), .bus_req_o(bus_req),
    .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
    .bus_err_i(bus_err)
  );

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut_to (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid_to), .ready_o(ready_to),
    .mem_op_i(mem_op), .addr_i(addr), .wdata_i(wdata), .done_o(done_to),
    .rdata_o(rdata_to), .exc_o(exc_to), .exc_cause_o(cause_to), .bus_req_o(bus_req_to),
    .bus_we_o(bus_we_to), .bus_addr_o(bus_addr_to), .bus_be_o(bus_be_to),
    .bus_wdata_o(bus_wdata_to), .bus_ack_i(bus_ack_to), .bus_rdata_i(bus_rdata),
    .bus_err_i(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: access size decides alignment, enables, replication and extension.
  function automatic void model(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdv, input bit err, output bit bus,
                                output logic [3:0] be, output logic [31:0] bwd,
                                output logic [31:0] rd, output bit ex, output logic [31:0] cs);
    int unsigned size, off;
    bit ld;
    logic [31:0] mask, v;
    ld = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: size = 1;
      MEM_LH, MEM_LHU, MEM_SH: size = 2;
      MEM_LW, MEM_SW:          size = 4;
      default:                 size = 0;
    endcase
    off = a % 4;
    bus = 0; be = '0; bwd = '0; rd = '0; ex = 0; cs = '0;
    if (size == 0) return;
    if (off % size != 0) begin
      ex = 1; cs = ld ? 32'd4 : 32'd6;
      return;
    end
    bus  = 1;
    be   = 4'(((1 << size) - 1) << off);
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
    bwd  = (wd & mask) * ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'd1);
    if (err) begin
      ex = 1; cs = ld ? 32'd5 : 32'd7;
      return;
    end
    if (ld) begin
      v = (rdv >> (8 * off)) & mask;
      if ((op == MEM_LB || op == MEM_LH) && v[8 * size - 1]) v = v | ~mask;
      rd = v;
    end
  endfunction

  task automatic do_op(input mem_op_t op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdv, input bit err, input int unsigned delay);
    bit bus_e, exc_e, st;
    logic [3:0] be_e;
    logic [31:0] bwd_e, rd_e, cs_e;
    model(op, a, wd, rdv, err, bus_e, be_e, bwd_e, rd_e, exc_e, cs_e);
    st = op inside {MEM_SB, MEM_SH, MEM_SW};
    @(negedge clk);
    chkb("ready_before", ready, 1'b1);
    req_valid = 1'b1; mem_op = op; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; mem_op = MEM_NOP; addr = $urandom; wdata = $urandom;
    if (!bus_e) begin
      chkb("nobus_req", bus_req, 1'b0);
      chkb("nobus_done", done, 1'b1);
      chkb("nobus_exc", exc, exc_e);
      chk("nobus_cause", cause, cs_e);
      chk("nobus_rdata", rdata, rd_e);
    end else begin
      for (int unsigned i = 0; i <= delay; i++) begin
        chkb("req_held", bus_req, 1'b1);
        chkb("ready_busy", ready, 1'b0);
        chkb("done_early", done, 1'b0);
        chk("bus_addr", bus_addr, {a[31:2], 2'b00});
        chk("bus_be", 32'(bus_be), 32'(be_e));
        chkb("bus_we", bus_we, st);
        if (st) chk("bus_wdata", bus_wdata, bwd_e);
        if (i == delay) begin
          bus_ack = 1'b1; bus_rdata = rdv; bus_err = err;
        end else begin
          bus_rdata = $urandom; bus_err = 1'($urandom);
        end
        @(negedge clk);
      end
      bus_ack = 1'b0; bus_rdata = $urandom; bus_err = 1'($urandom);
      chkb("req_drop", bus_req, 1'b0);
      chkb("done_gap", done, 1'b0);
      @(negedge clk);
      chkb("done", done, 1'b1);
      chkb("exc", exc, exc_e);
      chk("cause", cause, cs_e);
      chk("rdata", rdata, rd_e);
    end
    @(negedge clk);
    chkb("done_once", done, 1'b0);
    chkb("ready_after", ready, 1'b1);
  endtask

  task automatic do_timeout(input mem_op_t op, input logic [31:0] a, input logic [31:0] cs_e);
    @(negedge clk);
    chkb("to_ready", ready_to, 1'b1);
    req_valid_to = 1'b1; mem_op = op; addr = a; wdata = $urandom;
    @(negedge clk);
    req_valid_to = 1'b0; mem_op = MEM_NOP;
    for (int unsigned i = 0; i < TO; i++) begin
      chkb("to_req_held", bus_req_to, 1'b1);
      chkb("to_done_early", done_to, 1'b0);
      @(negedge clk);
    end
    chkb("to_req_drop", bus_req_to, 1'b0);
    chkb("to_done_gap", done_to, 1'b0);
    @(negedge clk);
    chkb("to_done", done_to, 1'b1);
    chkb("to_exc", exc_to, 1'b1);
    chk("to_cause", cause_to, cs_e);
    bus_ack_to = 1'b1;
    @(negedge clk);
    bus_ack_to = 1'b0;
    chkb("stray_done", done_to, 1'b0);
    chkb("stray_ready", ready_to, 1'b1);
    chkb("stray_req", bus_req_to, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_valid_to = 1'b0; bus_ack = 1'b0; bus_ack_to = 1'b0;
    bus_err = 1'b0; mem_op = MEM_NOP; addr = '0; wdata = '0; bus_rdata = '0;
    #12;
    chkb("rst_ready", ready, 1'b1);
    chkb("rst_done", done, 1'b0);
    chkb("rst_exc", exc, 1'b0);
    chkb("rst_req", bus_req, 1'b0);
    chkb("rst_we", bus_we, 1'b0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_cause", cause, 32'd0);
    chkb("rst_to_req", bus_req_to, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(MEM_LB,  32'h103, 32'h0,         32'h80FF_FF12, 1'b0, 0);
    do_op(MEM_LHU, 32'h202, 32'h0,         32'h8001_0000, 1'b0, 0);
    do_op(MEM_SB,  32'h301, 32'h0000_00AB, 32'h0,         1'b0, 0);
    do_op(MEM_SW,  32'h402, 32'h1234_5678, 32'h0,         1'b0, 0);
    do_op(MEM_LH,  32'h401, 32'h0,         32'h0,         1'b0, 0);
    do_op(MEM_NOP, 32'h500, 32'hFFFF_FFFF, 32'h0,         1'b0, 0);
    do_op(MEM_LW,  32'h600, 32'h0,         32'hDEAD_BEEF, 1'b0, 5);
    do_op(MEM_LW,  32'h604, 32'h0,         32'hCAFE_F00D, 1'b1, 5);
    do_op(MEM_SH,  32'h706, 32'h0000_BEEF, 32'h0,         1'b1, 1);

    do_timeout(MEM_LW, 32'h800, 32'd5);
    do_timeout(MEM_SH, 32'h902, 32'd7);

    for (int n = 0; n < 40; n++)
      do_op(mem_op_t'($urandom_range(0, 8)), $urandom, $urandom, $urandom,
            ($urandom_range(0, 7) == 0), $urandom_range(0, 3));

    @(negedge clk);
    req_valid = 1'b1; mem_op = MEM_LW; addr = 32'hA00;
    @(negedge clk);
    req_valid = 1'b0;
    chkb("mid_req", bus_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chkb("arst_req", bus_req, 1'b0);
    chkb("arst_ready", ready, 1'b1);
    chkb("arst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkb("post_rst_done", done, 1'b0);
      chkb("post_rst_ready", ready, 1'b1);
      chkb("post_rst_req", bus_req, 1'b0);
    end

    do_op(MEM_LBU, 32'hB01, 32'h0, 32'h0000_F700, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
